// File: rtl/fetcher_pkg.sv
// Shared types for the instruction-fetch stage: bus payloads, pipeline register, FSM states.
package fetcher_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    localparam addr_t RESET_PC_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic   valid;
        addr_t  addr;
        msize_t size;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef struct packed {
        logic            valid;
        logic [ILEN-1:0] inst;
        addr_t           inst_pc;
        logic [XLEN-1:0] inst_counter;
    } if_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetcher_align.sv
// Picks the 32-bit instruction out of a 64-bit bus beat using pc[2].
module fetch_align
    import fetcher_pkg::*;
(
    input  word_t           data,
    input  logic            sel_hi,
    output logic [ILEN-1:0] inst_c
);

    // Upper half holds the word at pc[2]=1
    always_comb begin
        inst_c = sel_hi ? data[XLEN-1:ILEN] : data[ILEN-1:0];
    end

endmodule

// File: rtl/fetcher.sv
// Instruction-fetch stage: owns the PC, issues single-beat reads, fills if_id.
module fetcher
    import fetcher_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp,
    input  logic       stall,
    input  logic       redirect_valid,
    input  addr_t      redirect_pc,
    output if_id_t     if_id_state
);

    fetch_state_t    state_q, state_n;
    addr_t           pc_q, pc_n;
    addr_t           pc_pending_q, pc_pending_n;
    logic            drop_q, drop_n;
    logic [ILEN-1:0] buf_inst_q, buf_inst_n;
    addr_t           buf_pc_q, buf_pc_n;
    logic [XLEN-1:0] inst_cnt_q, inst_cnt_n;
    if_id_t          if_id_q, if_id_n;
    ibus_req_t       ireq_q, ireq_n;
    logic [ILEN-1:0] inst_c;
    logic            unused_addr_ok;

    // Single-beat reads: the address-accept handshake carries no information here
    assign unused_addr_ok = iresp.addr_ok;

    fetch_align u_align (
        .data   (iresp.data),
        .sel_hi (pc_q[2]),
        .inst_c (inst_c)
    );

    // Next-state, PC and pipeline-register update
    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        pc_pending_n = pc_pending_q;
        drop_n       = drop_q;
        buf_inst_n   = buf_inst_q;
        buf_pc_n     = buf_pc_q;
        inst_cnt_n   = inst_cnt_q;
        if_id_n      = if_id_q;
        if_id_n.valid = stall ? if_id_q.valid : 1'b0;

        unique case (state_q)
            IDLE: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (iresp.data_ok) begin
                    if (redirect_valid) begin
                        pc_n   = redirect_pc;
                        drop_n = 1'b0;
                    end else if (drop_q) begin
                        pc_n   = pc_pending_q;
                        drop_n = 1'b0;
                    end else if (stall) begin
                        buf_inst_n = inst_c;
                        buf_pc_n   = pc_q;
                        state_n    = HOLD;
                    end else begin
                        if_id_n.valid        = 1'b1;
                        if_id_n.inst         = inst_c;
                        if_id_n.inst_pc      = pc_q;
                        if_id_n.inst_counter = inst_cnt_q;
                        inst_cnt_n           = inst_cnt_q + 64'd1;
                        pc_n                 = pc_q + 64'd4;
                    end
                end else if (redirect_valid) begin
                    // Read still in flight: remember the target, discard its data later
                    drop_n       = 1'b1;
                    pc_pending_n = redirect_pc;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = FETCH;
                end else if (!stall) begin
                    if_id_n.valid        = 1'b1;
                    if_id_n.inst         = buf_inst_q;
                    if_id_n.inst_pc      = buf_pc_q;
                    if_id_n.inst_counter = inst_cnt_q;
                    inst_cnt_n           = inst_cnt_q + 64'd1;
                    pc_n                 = pc_q + 64'd4;
                    state_n              = FETCH;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A redirect always flushes whatever decode would see next
        if (redirect_valid) begin
            if_id_n.valid = 1'b0;
        end

        ireq_n.valid = (state_n == FETCH);
        ireq_n.addr  = pc_n;
        ireq_n.size  = MSIZE4;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pc_pending_q <= '0;
            drop_q       <= 1'b0;
            buf_inst_q   <= '0;
            buf_pc_q     <= '0;
            inst_cnt_q   <= '0;
            if_id_q      <= '0;
            ireq_q       <= '0;
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            pc_pending_q <= pc_pending_n;
            drop_q       <= drop_n;
            buf_inst_q   <= buf_inst_n;
            buf_pc_q     <= buf_pc_n;
            inst_cnt_q   <= inst_cnt_n;
            if_id_q      <= if_id_n;
            ireq_q       <= ireq_n;
        end
    end

    assign ireq        = ireq_q;
    assign if_id_state = if_id_q;

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher: memory responder + request-level reference model + scoreboard.
module tb_fetcher;
    import fetcher_pkg::*;

    localparam addr_t RST_PC = 64'h8000_0000;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    logic       stall;
    logic       redirect_valid;
    addr_t      redirect_pc;
    if_id_t     if_id_state;

    fetcher #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_state    (if_id_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        addr_t       pc;
        logic [63:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   popped = 0;

    // Reference model: one outstanding request, at most one parked instruction
    addr_t       exp_addr;
    addr_t       cur_addr;
    addr_t       parked_pc;
    logic        inflight;
    logic        doomed;
    logic        parked;
    int          lat;
    logic [63:0] cnt;

    int   stall_pct;
    int   redir_pct;
    int   max_lat;
    logic hold_mem;

    function automatic logic [31:0] mem_word(addr_t a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] inst_at(addr_t a);
        return mem_word({a[63:3], a[2], 2'b00});
    endfunction

    function automatic addr_t pick_target();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
        if (r == 1) return RST_PC + 64'($urandom_range(0, 63) * 4) + 64'd1;
        return RST_PC + 64'($urandom_range(0, 255) * 4);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input addr_t a);
        exp_t e;
        e.inst = inst_at(a);
        e.pc   = a;
        e.cnt  = cnt;
        exp_q.push_back(e);
        pushed++;
        cnt      = cnt + 64'd1;
        exp_addr = a + 64'd4;
    endtask

    // One cycle of stimulus; called just after a rising edge
    task automatic step();
        logic  dok;
        logic  rdr;
        logic  stl;
        addr_t tgt;

        if (parked) begin
            check64("ireq_valid_in_hold", 64'(ireq.valid), 64'd0);
        end else if (!inflight) begin
            check64("ireq_new_valid", 64'(ireq.valid), 64'd1);
            check64("ireq_new_addr", ireq.addr, exp_addr);
            check64("ireq_size", 64'(ireq.size), 64'(MSIZE4));
            inflight = 1'b1;
            cur_addr = exp_addr;
            doomed   = 1'b0;
            lat      = int'($urandom_range(0, max_lat));
        end else begin
            check64("ireq_stable_valid", 64'(ireq.valid), 64'd1);
            check64("ireq_stable_addr", ireq.addr, cur_addr);
        end

        dok = inflight && (lat == 0) && !hold_mem;
        if (inflight && lat > 0) lat--;
        rdr = (inflight || parked) && (int'($urandom_range(0, 99)) < redir_pct);
        stl = int'($urandom_range(0, 99)) < stall_pct;
        tgt = pick_target();

        iresp.addr_ok  = ireq.valid;
        iresp.data_ok  = dok;
        iresp.data     = dok ? {mem_word({cur_addr[63:3], 3'b100}), mem_word({cur_addr[63:3], 3'b000})}
                             : {$urandom, $urandom};
        redirect_valid = rdr;
        redirect_pc    = rdr ? tgt : {$urandom, $urandom};
        stall          = stl;

        if (parked) begin
            if (rdr) begin
                parked   = 1'b0;
                exp_addr = tgt;
            end else if (!stl) begin
                parked = 1'b0;
                push_exp(parked_pc);
            end
        end
        if (inflight) begin
            if (rdr) begin
                doomed   = 1'b1;
                exp_addr = tgt;
            end
            if (dok) begin
                inflight = 1'b0;
                if (!doomed) begin
                    if (stl) begin
                        parked    = 1'b1;
                        parked_pc = cur_addr;
                    end else begin
                        push_exp(cur_addr);
                    end
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(posedge clk);
            #1;
        end
    endtask

    // Reset with a stray data_ok on the bus during and right after it
    task automatic do_reset(input int cycles);
        reset          = 1'b1;
        iresp.addr_ok  = 1'b0;
        iresp.data_ok  = 1'b1;
        iresp.data     = {$urandom, $urandom};
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (cycles) @(posedge clk);
        #1;
        check64("rst_ireq_valid", 64'(ireq.valid), 64'd0);
        check64("rst_if_id_valid", 64'(if_id_state.valid), 64'd0);
        check64("rst_if_id_pc", if_id_state.inst_pc, 64'd0);
        check64("rst_if_id_cnt", if_id_state.inst_counter, 64'd0);
        check64("rst_if_id_inst", 64'(if_id_state.inst), 64'd0);
        reset    = 1'b0;
        pushed   = pushed - exp_q.size();
        exp_q.delete();
        inflight = 1'b0;
        parked   = 1'b0;
        doomed   = 1'b0;
        cnt      = '0;
        exp_addr = RST_PC;
        @(posedge clk);
        #1;
        iresp.data_ok = 1'b0;
    endtask

    // Monitor: checks each freshly loaded if_id entry and that stalled entries hold
    logic        prev_stall = 1'b0;
    addr_t       last_pc = '0;
    logic [63:0] last_cnt = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && if_id_state.valid) begin
            if (!prev_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL if_id_unexpected: got pc %h cnt %0d, required no entry", if_id_state.inst_pc, if_id_state.inst_counter);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    check64("if_id_inst", 64'(if_id_state.inst), 64'(e.inst));
                    check64("if_id_pc", if_id_state.inst_pc, e.pc);
                    check64("if_id_cnt", if_id_state.inst_counter, e.cnt);
                    last_pc  = e.pc;
                    last_cnt = e.cnt;
                end
            end else begin
                check64("if_id_hold_pc", if_id_state.inst_pc, last_pc);
                check64("if_id_hold_cnt", if_id_state.inst_counter, last_cnt);
            end
        end
        prev_stall = stall;
    end

    initial begin
        int guard;
        stall_pct = 0;
        redir_pct = 0;
        max_lat   = 0;
        hold_mem  = 1'b0;
        do_reset(2);

        // Zero-wait memory, no stall: one instruction per cycle
        run(12);

        // Variable latency with stalls and redirects
        max_lat   = 3;
        stall_pct = 30;
        redir_pct = 10;
        run(1500);

        // Reset while a read is outstanding
        guard = 0;
        while (!(inflight && lat > 0) && guard < 50) begin
            run(1);
            guard++;
        end
        do_reset(1);

        // Heavier stall/redirect mix
        stall_pct = 50;
        redir_pct = 20;
        run(1500);

        // Drain: no new data, no stall, no redirect
        hold_mem  = 1'b1;
        stall_pct = 0;
        redir_pct = 0;
        run(6);
        iresp.data_ok = 1'b0;
        stall         = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check64("pushed_eq_popped", 64'(popped), 64'(pushed));
        check64("enough_traffic", 64'(popped > 300), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
